// File: rtl/presc_pkg.sv
// presc_pkg: shared defaults and divisor type for the multi-channel prescaler.
package presc_pkg;
    localparam int CNT_W_DEF       = 16;
    localparam int DEFAULT_DIV_DEF = 50;
    typedef logic [CNT_W_DEF-1:0] div_t;
endpackage

// File: rtl/presc_chan.sv
// presc_chan: one divider channel with tick strobe, 50% divided clock and boundary-applied reload.
module presc_chan
    import presc_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_in_p,
    input  logic             rst_p,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);
    logic [CNT_W-1:0] cnt, act_div, pend_div;
    logic run, tc, apply;
    assign run = en && act_div != '0;
    assign tc = cnt == act_div - 1'b1;
    // a pending divisor lands only where the counter restarts, so no period is ever cut short
    assign apply = pend && (!run || sync || tc);
    always_ff @(posedge clk_in_p) begin
        if (rst_p) begin
            cnt      <= '0;
            act_div  <= CNT_W'(DEFAULT_DIV);
            pend_div <= CNT_W'(DEFAULT_DIV);
            pend     <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            if (apply) act_div <= pend_div;
            if (load) pend_div <= div;
            pend    <= load || (pend && !apply);
            cnt     <= (run && !sync && !tc) ? cnt + 1'b1 : '0;
            tick    <= run && !sync && tc;
            clk_out <= (!en || sync) ? 1'b0 : (run && tc) ? ~clk_out : clk_out;
        end
    end
endmodule

// File: rtl/presc_multi.sv
// presc_multi: CHANNELS independent runtime-programmable clock dividers.
// Define PRESC_SYNC_EN to let sync_p phase-align all enabled channels.
module presc_multi
    import presc_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                      clk_in_p,
    input  logic                      rst_p,
    input  logic [CHANNELS-1:0]       en_p,
    input  logic [CHANNELS*CNT_W-1:0] div_p,
    input  logic [CHANNELS-1:0]       load_p,
    input  logic                      sync_p,
    output logic [CHANNELS-1:0]       clk_out_p,
    output logic [CHANNELS-1:0]       tick_p,
    output logic [CHANNELS-1:0]       pend_p
);
    logic sync_int;
`ifdef PRESC_SYNC_EN
    assign sync_int = sync_p;
`else
    logic unused_sync;
    assign unused_sync = sync_p;
    assign sync_int = 1'b0;
`endif
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        presc_chan #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .clk_in_p(clk_in_p),
            .rst_p   (rst_p),
            .en      (en_p[i]),
            .sync    (sync_int),
            .load    (load_p[i]),
            .div     (div_p[i*CNT_W +: CNT_W]),
            .clk_out (clk_out_p[i]),
            .tick    (tick_p[i]),
            .pend    (pend_p[i])
        );
    end
endmodule

// File: tb/tb_presc_multi.sv
// tb_presc_multi: directed scenarios plus randomized run against an elapsed-cycle reference model.
module tb_presc_multi;
    logic        clk_in_p = 1'b0;
    logic        rst_p = 1'b0;
    logic [1:0]  en_p = '0;
    logic [31:0] div_p = '0;
    logic [1:0]  load_p = '0;
    logic        sync_p = 1'b0;
    logic [1:0]  clk_out_p, tick_p, pend_p;
    int n_checks = 0;
    int n_fail = 0;
    int m_phase[2], m_per[2], m_pdiv[2];
    logic [1:0] m_clk = '0, m_tick = '0, m_pend = '0;

    presc_multi dut (
        .clk_in_p (clk_in_p),
        .rst_p    (rst_p),
        .en_p     (en_p),
        .div_p    (div_p),
        .load_p   (load_p),
        .sync_p   (sync_p),
        .clk_out_p(clk_out_p),
        .tick_p   (tick_p),
        .pend_p   (pend_p)
    );

    initial forever #5 clk_in_p = ~clk_in_p;

    // model: phase counts cycles elapsed in the current period; a period ends when it reaches the divisor
    task automatic model_edge();
        bit syn;
`ifdef PRESC_SYNC_EN
        syn = sync_p;
`else
        syn = 1'b0;
`endif
        for (int c = 0; c < 2; c++) begin
            bit hold, wrap;
            if (rst_p) begin
                m_phase[c] = 0; m_per[c] = 50; m_pdiv[c] = 50;
                m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
            end else begin
                hold = !en_p[c] || syn || m_per[c] == 0;
                wrap = 0;
                if (hold) begin
                    m_phase[c] = 0;
                    m_tick[c] = 0;
                    if (!en_p[c] || syn) m_clk[c] = 0;
                end else begin
                    m_phase[c]++;
                    wrap = m_phase[c] == m_per[c];
                    m_tick[c] = wrap;
                    if (wrap) begin
                        m_phase[c] = 0;
                        m_clk[c] = ~m_clk[c];
                    end
                end
                if ((hold || wrap) && m_pend[c]) begin
                    m_per[c] = m_pdiv[c];
                    m_pend[c] = 0;
                end
                if (load_p[c]) begin
                    m_pdiv[c] = int'(div_p[c*16 +: 16]);
                    m_pend[c] = 1;
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_in_p);
        #1;
    endtask

    task automatic do_reset();
        rst_p = 1; en_p = 0; load_p = 0; sync_p = 0;
        step(); step();
        rst_p = 0;
    endtask

    task automatic load_disabled(input int d0, input int d1, input logic [1:0] which);
        en_p = 0; div_p = {16'(d1), 16'(d0)}; load_p = which;
        step();
        load_p = 0;
        step();
    endtask

    task automatic test_reset();
        rst_p = 1;
        for (int k = 0; k < 3; k++) begin
            en_p = 2'($urandom); load_p = 2'($urandom); div_p = $urandom;
            step();
            n_checks++;
            if ({clk_out_p, tick_p, pend_p} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset: out=%b tick=%b pend=%b, want all 0", clk_out_p, tick_p, pend_p);
            end
        end
        rst_p = 0; en_p = 0; load_p = 0;
        step();
        n_checks++;
        if ({clk_out_p, tick_p, pend_p} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_idle: out=%b tick=%b pend=%b, want all 0", clk_out_p, tick_p, pend_p);
        end
    endtask

    task automatic test_default();
        do_reset();
        en_p = 2'b01;
        for (int k = 1; k <= 250; k++) begin
            logic t, c;
            step();
            t = (k % 50) == 0;
            c = ((k / 50) % 2) == 1;
            n_checks++;
            if (tick_p !== {1'b0, t} || clk_out_p !== {1'b0, c} || pend_p !== 2'b00) begin
                n_fail++;
                $display("FAIL default_d50 k=%0d: tick=%b out=%b pend=%b, want tick=%b out=%b pend=00",
                         k, tick_p, clk_out_p, pend_p, {1'b0, t}, {1'b0, c});
            end
        end
    endtask

    task automatic test_small_div();
        int ds[2] = '{1, 3};
        do_reset();
        foreach (ds[j]) begin
            en_p = 0; div_p = 32'(ds[j]); load_p = 2'b01;
            step();
            n_checks++;
            if (pend_p !== 2'b01) begin
                n_fail++;
                $display("FAIL pend_set d=%0d: pend=%b want 01", ds[j], pend_p);
            end
            load_p = 0;
            step();
            n_checks++;
            if (pend_p !== 2'b00) begin
                n_fail++;
                $display("FAIL pend_apply_disabled d=%0d: pend=%b want 00", ds[j], pend_p);
            end
            en_p = 2'b01;
            for (int k = 1; k <= 12; k++) begin
                logic t, c;
                step();
                t = (k % ds[j]) == 0;
                c = ((k / ds[j]) % 2) == 1;
                n_checks++;
                if (tick_p !== {1'b0, t} || clk_out_p !== {1'b0, c}) begin
                    n_fail++;
                    $display("FAIL small_div d=%0d k=%0d: tick=%b out=%b want tick=%b out=%b",
                             ds[j], k, tick_p, clk_out_p, {1'b0, t}, {1'b0, c});
                end
            end
        end
    endtask

    task automatic test_reload_midperiod();
        do_reset();
        load_disabled(10, 0, 2'b01);
        en_p = 2'b01;
        for (int k = 1; k <= 30; k++) begin
            int tg;
            logic t, c, p;
            div_p = 32'd4;
            load_p = (k == 3) ? 2'b01 : 2'b00;
            step();
            tg = (k < 10) ? 0 : 1 + (k - 10) / 4;
            t = k >= 10 && ((k - 10) % 4) == 0;
            c = (tg % 2) == 1;
            p = k >= 3 && k < 10;
            n_checks++;
            if (tick_p !== {1'b0, t} || clk_out_p !== {1'b0, c} || pend_p !== {1'b0, p}) begin
                n_fail++;
                $display("FAIL reload_10_to_4 k=%0d: tick=%b out=%b pend=%b want %b %b %b",
                         k, tick_p, clk_out_p, pend_p, {1'b0, t}, {1'b0, c}, {1'b0, p});
            end
        end
        load_p = 0;
    endtask

    task automatic test_load_at_tc();
        do_reset();
        load_disabled(8, 0, 2'b01);
        en_p = 2'b01;
        for (int k = 1; k <= 35; k++) begin
            int tg;
            logic t, c, p;
            div_p = 32'd5;
            load_p = (k == 8) ? 2'b01 : 2'b00;
            step();
            tg = (k < 8) ? 0 : (k < 16) ? 1 : 2 + (k - 16) / 5;
            t = k == 8 || (k >= 16 && ((k - 16) % 5) == 0);
            c = (tg % 2) == 1;
            p = k >= 8 && k < 16;
            n_checks++;
            if (tick_p !== {1'b0, t} || clk_out_p !== {1'b0, c} || pend_p !== {1'b0, p}) begin
                n_fail++;
                $display("FAIL load_at_tc k=%0d: tick=%b out=%b pend=%b want %b %b %b",
                         k, tick_p, clk_out_p, pend_p, {1'b0, t}, {1'b0, c}, {1'b0, p});
            end
        end
        load_p = 0;
    endtask

    task automatic test_reset_midperiod();
        do_reset();
        load_disabled(8, 0, 2'b01);
        en_p = 2'b01;
        for (int k = 1; k <= 15; k++) begin
            div_p = 32'd3;
            load_p = (k == 15) ? 2'b01 : 2'b00;
            step();
        end
        load_p = 0;
        n_checks++;
        if (clk_out_p !== 2'b01 || pend_p !== 2'b01) begin
            n_fail++;
            $display("FAIL pre_reset_state: out=%b pend=%b want 01 01", clk_out_p, pend_p);
        end
        rst_p = 1;
        step();
        rst_p = 0;
        n_checks++;
        if ({clk_out_p, tick_p, pend_p} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_reset: out=%b tick=%b pend=%b want all 0", clk_out_p, tick_p, pend_p);
        end
        for (int k = 1; k <= 50; k++) begin
            step();
            n_checks++;
            if (tick_p !== {1'b0, k == 50} || pend_p !== 2'b00) begin
                n_fail++;
                $display("FAIL post_reset_default k=%0d: tick=%b pend=%b want tick=%b pend=00",
                         k, tick_p, pend_p, {1'b0, k == 50});
            end
        end
    endtask

`ifdef PRESC_SYNC_EN
    task automatic test_sync();
        do_reset();
        load_disabled(6, 4, 2'b11);
        en_p = 2'b11;
        repeat ($urandom_range(5, 30)) step();
        sync_p = 1;
        step();
        sync_p = 0;
        n_checks++;
        if (clk_out_p !== 2'b00 || tick_p !== 2'b00) begin
            n_fail++;
            $display("FAIL sync_pulse: out=%b tick=%b want 00 00", clk_out_p, tick_p);
        end
        for (int k = 1; k <= 48; k++) begin
            logic [1:0] t, c;
            step();
            t = {(k % 4) == 0, (k % 6) == 0};
            c = {((k / 4) % 2) == 1, ((k / 6) % 2) == 1};
            n_checks++;
            if (tick_p !== t || clk_out_p !== c) begin
                n_fail++;
                $display("FAIL sync_aligned k=%0d: tick=%b out=%b want %b %b", k, tick_p, clk_out_p, t, c);
            end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            rst_p = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 19) == 0) en_p = 2'($urandom);
            load_p = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0};
            div_p = {16'($urandom_range(0, 7)), 16'($urandom_range(0, 7))};
            sync_p = $urandom_range(0, 29) == 0;
            step();
            n_checks++;
            if ({clk_out_p, tick_p, pend_p} !== {m_clk, m_tick, m_pend}) begin
                n_fail++;
                $display("FAIL random k=%0d: out=%b tick=%b pend=%b want %b %b %b",
                         k, clk_out_p, tick_p, pend_p, m_clk, m_tick, m_pend);
            end
        end
        rst_p = 0; load_p = 0; sync_p = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_default();
        test_small_div();
        test_reload_midperiod();
        test_load_at_tc();
        test_reset_midperiod();
`ifdef PRESC_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
